// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared core package: writeback source select encodings
package writeback_pkg;

  typedef enum logic [1:0] {
    WBSEL_ALU = 2'b00,
    WBSEL_MEM = 2'b01,
    WBSEL_PC4 = 2'b10,
    WBSEL_DEF = 2'b11
  } wbsel_e;

endpackage

// File: rtl/writeback.sv
// rtl/writeback.sv - writeback stage: register-file data select, next-PC select
// and a registered trace copy of both for commit logging.
module writeback
  import writeback_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] memory_data_i,
  input  logic [1:0]        wbsel_i,
  input  logic              brtaken_i,
  output logic [DWIDTH-1:0] writeback_data_o,
  output logic [AWIDTH-1:0] next_pc_o,
  output logic [DWIDTH-1:0] wb_data_q_o,
  output logic [AWIDTH-1:0] next_pc_q_o
);

  logic [AWIDTH-1:0] pc4;
  logic [DWIDTH-1:0] wb_data_d, wb_data_q;
  logic [AWIDTH-1:0] next_pc_d, next_pc_q;

  // Carry out of the increment is dropped: the PC wraps modulo 2^AWIDTH.
  assign pc4 = pc_i + AWIDTH'(4);

  always_comb begin
    writeback_data_o = '0;
    case (wbsel_i)
      WBSEL_ALU: writeback_data_o = alu_res_i;
      WBSEL_MEM: writeback_data_o = memory_data_i;
      WBSEL_PC4: writeback_data_o = DWIDTH'(pc4);
      default:   writeback_data_o = '0;
    endcase
  end

  // A PC4 writeback marks JAL/JALR, which always redirects to the ALU target.
  assign next_pc_o = (brtaken_i || (wbsel_i == WBSEL_PC4)) ? AWIDTH'(alu_res_i) : pc4;

  always_comb begin
    wb_data_d = writeback_data_o;
    next_pc_d = next_pc_o;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_q <= '0;
      next_pc_q <= '0;
    end else begin
      wb_data_q <= wb_data_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign wb_data_q_o = wb_data_q;
  assign next_pc_q_o = next_pc_q;

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - scoreboard bench for writeback: directed cases then random
// vectors, combinational and trace outputs checked against a reference model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_i = '0;
  logic [31:0] alu_res_i = '0;
  logic [31:0] memory_data_i = '0;
  logic [1:0]  wbsel_i = '0;
  logic        brtaken_i = 1'b0;
  logic [31:0] writeback_data_o;
  logic [31:0] next_pc_o;
  logic [31:0] wb_data_q_o;
  logic [31:0] next_pc_q_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] wb;
    logic [31:0] npc;
    string       name;
  } exp_t;

  exp_t comb_q[$];
  exp_t trace_q[$];

  writeback #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_i             (pc_i),
    .alu_res_i        (alu_res_i),
    .memory_data_i    (memory_data_i),
    .wbsel_i          (wbsel_i),
    .brtaken_i        (brtaken_i),
    .writeback_data_o (writeback_data_o),
    .next_pc_o        (next_pc_o),
    .wb_data_q_o      (wb_data_q_o),
    .next_pc_q_o      (next_pc_q_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic from the stage rules.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] alu,
                                 input logic [31:0] mem, input logic [1:0] sel,
                                 input logic br, input string name);
    exp_t e;
    longint unsigned inc;
    logic [31:0] ret_addr;
    inc = (longint'(pc) + 4) % 64'h1_0000_0000;
    ret_addr = inc[31:0];
    if (sel == 2'd0)      e.wb = alu;
    else if (sel == 2'd1) e.wb = mem;
    else if (sel == 2'd2) e.wb = ret_addr;
    else                  e.wb = 32'h0;
    e.npc  = (br || sel == 2'd2) ? alu : ret_addr;
    e.name = name;
    return e;
  endfunction

  task automatic apply(input logic rst, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [1:0] sel, input logic br,
                       input string name);
    exp_t e, t;
    @(posedge clk);
    #2;
    reset = rst; pc_i = pc; alu_res_i = alu; memory_data_i = mem;
    wbsel_i = sel; brtaken_i = br;
    e = model(pc, alu, mem, sel, br, name);
    comb_q.push_back(e);
    t = e;
    if (rst) begin
      t.wb = 32'h0;
      t.npc = 32'h0;
    end
    trace_q.push_back(t);
  endtask

  // Combinational monitor: mid-cycle, after inputs settle.
  always @(negedge clk) begin
    exp_t e;
    if (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      vectors++;
      if (writeback_data_o !== e.wb) begin
        miscompares++;
        $display("FAIL %s wb: got %08h expected %08h", e.name, writeback_data_o, e.wb);
      end
      vectors++;
      if (next_pc_o !== e.npc) begin
        miscompares++;
        $display("FAIL %s next_pc: got %08h expected %08h", e.name, next_pc_o, e.npc);
      end
    end
  end

  // Trace monitor: just after the edge that captured the vector.
  always @(posedge clk) begin
    exp_t t;
    #1;
    if (trace_q.size() > 0) begin
      t = trace_q.pop_front();
      vectors++;
      if (wb_data_q_o !== t.wb) begin
        miscompares++;
        $display("FAIL %s wb_data_q: got %08h expected %08h", t.name, wb_data_q_o, t.wb);
      end
      vectors++;
      if (next_pc_q_o !== t.npc) begin
        miscompares++;
        $display("FAIL %s next_pc_q: got %08h expected %08h", t.name, next_pc_q_o, t.npc);
      end
    end
  end

  initial begin
    logic [1:0] sel;
    logic [31:0] pc;
    apply(1, 32'h0000_0000, 32'h0, 32'h0, 2'd0, 0, "rst0");
    apply(1, 32'h0000_0000, 32'h0, 32'h0, 2'd0, 0, "rst1");
    apply(0, 32'h0000_1000, 32'h0000_0042, 32'h0, 2'd0, 0, "release");
    apply(0, 32'h0000_1000, 32'h1234_5678, 32'h0, 2'd0, 0, "alu");
    apply(0, 32'h0000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 2'd1, 0, "mem");
    apply(0, 32'h0000_2000, 32'h0000_3008, 32'h0, 2'd2, 0, "jal");
    apply(0, 32'hFFFF_FFFC, 32'hAAAA_AAAA, 32'h0, 2'd2, 0, "jal_wrap");
    apply(0, 32'h0000_2000, 32'h0000_2100, 32'h0, 2'd0, 1, "br_taken");
    apply(0, 32'h0000_3000, 32'h0000_3100, 32'h0, 2'd0, 0, "br_not");
    apply(0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 2'd1, 0, "pc_ffff");
    apply(0, 32'h0000_5000, 32'h1111_1111, 32'h2222_2222, 2'd3, 0, "sel_def");
    apply(0, 32'h0000_6000, 32'h0000_7000, 32'h0, 2'd2, 1, "jal_br");
    apply(1, 32'h0000_8000, 32'h0000_0055, 32'h0, 2'd0, 0, "rst_mid");
    apply(0, 32'h0000_8000, 32'h0000_0055, 32'h0, 2'd0, 0, "resume");
    for (int i = 0; i < 300; i++) begin
      sel = 2'($urandom_range(0, 3));
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
      apply(($urandom_range(0, 19) == 0), pc, $urandom, $urandom, sel,
            1'($urandom_range(0, 1)), "rand");
    end
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (comb_q.size() != 0 || trace_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", comb_q.size(), trace_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
